// File: rtl/baud_tick_gen_pkg.sv
// baud_tick_gen_pkg: standard baud rates, select encoding and fixed-point divisor helper
package baud_tick_gen_pkg;
  localparam int BAUD_2400 = 2400;
  localparam int BAUD_9600 = 9600;
  localparam int BAUD_19200 = 19200;
  localparam int BAUD_115200 = 115200;
  localparam int INT_W_DEF = 16;
  localparam int FRAC_W_DEF = 8;
  localparam int DIV_W = INT_W_DEF + FRAC_W_DEF;
  typedef enum logic [1:0] {
    SEL_B0 = 2'b00,
    SEL_B1 = 2'b01,
    SEL_B2 = 2'b10,
    SEL_CUST = 2'b11
  } sel_t;
  // {int,frac} of freq/(baud*os), fraction rounded to nearest; a rounding carry lands in int
  function automatic longint calc_div(input longint freq, input longint baud, input longint os, input int frac_w);
    return ((freq <<< (frac_w + 1)) + baud * os) / (2 * baud * os);
  endfunction
endpackage

// File: rtl/baud_tick_gen_if.sv
// baud_tick_gen_if: control and strobe bundle between a UART and its baud generator
interface baud_tick_gen_if #(
  parameter int INT_W = 16,
  parameter int FRAC_W = 8
);
  import baud_tick_gen_pkg::*;
  logic en;
  sel_t baud_sel;
  logic div_we;
  logic [INT_W+FRAC_W-1:0] div_in;
  logic tick_os;
  logic tick_bit;
  logic baud_out;
  logic sel_pending;
  modport master (
    output en, baud_sel, div_we, div_in,
    input tick_os, tick_bit, baud_out, sel_pending
  );
  modport slave (
    input en, baud_sel, div_we, div_in,
    output tick_os, tick_bit, baud_out, sel_pending
  );
endinterface

// File: rtl/baud_tick_gen_frac_div.sv
// baud_tick_gen_frac_div: period counter with fractional accumulator (BAUD_TICK_GEN_FRAC_EN) producing tick_os
module baud_tick_gen_frac_div #(
  parameter int INT_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic [INT_W+FRAC_W-1:0] div,
  output logic tick_os
);
  localparam logic [INT_W:0] ONE = 1;
  localparam logic [INT_W:0] TWO = 2;
  logic [INT_W:0] cnt, base, per;
  logic wrap;
`ifdef BAUD_TICK_GEN_FRAC_EN
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0] sum;
  logic carry;
  assign base = {1'b0, div[INT_W+FRAC_W-1:FRAC_W]};
  assign sum = {1'b0, acc} + {1'b0, div[FRAC_W-1:0]};
  assign per = (base < TWO ? TWO : base) + {{INT_W{1'b0}}, carry};
  // add the fraction on every tick; its carry stretches the following period by one cycle
  always_ff @(posedge clk)
    if (rst || !en) begin
      acc <= '0;
      carry <= 1'b0;
    end else if (wrap) begin
      acc <= sum[FRAC_W-1:0];
      carry <= sum[FRAC_W];
    end
`else
  logic unused_frac;
  assign unused_frac = ^div[FRAC_W-2:0];
  assign base = {1'b0, div[INT_W+FRAC_W-1:FRAC_W]} + {{INT_W{1'b0}}, div[FRAC_W-1]};
  assign per = base < TWO ? TWO : base;
`endif
  assign wrap = cnt >= per - ONE;
  // count 0..per-1 and strobe in the cycle after the last count; >= keeps a shrunk period from stalling
  always_ff @(posedge clk)
    if (rst || !en) begin
      cnt <= '0;
      tick_os <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + ONE;
      tick_os <= wrap;
    end
endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: UART baud generator with glitch-free rate switching; BAUD_TICK_GEN_FRAC_EN enables fractional divisors
module baud_tick_gen
  import baud_tick_gen_pkg::*;
#(
  parameter int FREQ = 50000000,
  parameter int OVERSAMPLE = 16,
  parameter int BAUD_0 = BAUD_2400,
  parameter int BAUD_1 = BAUD_9600,
  parameter int BAUD_2 = BAUD_19200,
  parameter int INT_W = INT_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int CUSTOM_RST = BAUD_115200
) (
  input logic clk,
  input logic rst,
  baud_tick_gen_if.slave bus
);
  localparam int DW = INT_W + FRAC_W;
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0] DIV_0 = DW'(calc_div(FREQ, BAUD_0, OVERSAMPLE, FRAC_W));
  localparam logic [DW-1:0] DIV_1 = DW'(calc_div(FREQ, BAUD_1, OVERSAMPLE, FRAC_W));
  localparam logic [DW-1:0] DIV_2 = DW'(calc_div(FREQ, BAUD_2, OVERSAMPLE, FRAC_W));
  localparam logic [DW-1:0] DIV_C = DW'(calc_div(FREQ, CUSTOM_RST, OVERSAMPLE, FRAC_W));
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);
  sel_t act_sel;
  logic [DW-1:0] cust, cust_act, div;
  logic [OSW-1:0] os_cnt;
  logic tick_os, tick_bit, apply;
  assign div = act_sel == SEL_CUST ? cust_act : act_sel == SEL_B2 ? DIV_2 : act_sel == SEL_B1 ? DIV_1 : DIV_0;
  assign tick_bit = tick_os && os_cnt == OS_LAST;
  assign apply = !bus.en || tick_bit;
  assign bus.tick_os = tick_os;
  assign bus.tick_bit = tick_bit;
  baud_tick_gen_frac_div #(.INT_W(INT_W), .FRAC_W(FRAC_W)) u_div (
    .clk(clk),
    .rst(rst),
    .en(bus.en),
    .div(div),
    .tick_os(tick_os)
  );
  // rate and custom divisor switch only on a bit boundary (or while idle) so no bit is ever cut or stretched
  always_ff @(posedge clk)
    if (rst) begin
      act_sel <= bus.baud_sel;
      cust <= DIV_C;
      cust_act <= DIV_C;
      bus.sel_pending <= 1'b0;
    end else begin
      if (bus.div_we) cust <= bus.div_in;
      if (apply) begin
        act_sel <= bus.baud_sel;
        cust_act <= cust;
      end
      bus.sel_pending <= !apply && bus.baud_sel != act_sel;
    end
  // oversample position within the bit and the half-bit square wave derived from it
  always_ff @(posedge clk)
    if (rst || !bus.en) begin
      os_cnt <= '0;
      bus.baud_out <= 1'b0;
    end else if (tick_os) begin
      os_cnt <= tick_bit ? '0 : os_cnt + OSW'(1);
      bus.baud_out <= bus.baud_out ^ (os_cnt == OS_HALF || tick_bit);
    end
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: table-driven and scenario checks of tick spacing, strobes and rate switching
module tb_baud_tick_gen;
  import baud_tick_gen_pkg::*;
  localparam int OS = 16;
  localparam int LIMIT = 25000;
  typedef struct {
    sel_t sel;
    bit we;
    int i;
    int f;
    int n;
  } tv_t;
  typedef struct {
    int gap;
    bit tb;
    bit bo;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int cyc = 0;
  int last = 0;
  int k = 0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  tv_t tbl[9];
`ifdef BAUD_TICK_GEN_FRAC_EN
  int acc = 0;
  int carry = 0;
`endif
  baud_tick_gen_if #(.INT_W(16), .FRAC_W(8)) bus ();
  baud_tick_gen dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always_ff @(posedge clk) cyc <= cyc + 1;
  function automatic void mdl_reset();
    k = 0;
`ifdef BAUD_TICK_GEN_FRAC_EN
    acc = 0;
    carry = 0;
`endif
  endfunction
  function automatic int mdl_gap(input int i, input int f);
    int g;
`ifdef BAUD_TICK_GEN_FRAC_EN
    g = (i < 2 ? 2 : i) + carry;
    acc = acc + f;
    carry = acc >= 256 ? 1 : 0;
    acc = acc % 256;
`else
    g = i + (f >= 128 ? 1 : 0);
    g = g < 2 ? 2 : g;
`endif
    return g;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_tick(input int i, input int f);
    exp_t e;
    int g;
    e.gap = mdl_gap(i, f);
    e.tb = (k % OS) == OS - 1;
    e.bo = (k % OS) >= OS / 2;
    sb.push_back(e);
    forever begin
      @(negedge clk);
      if (bus.tick_os || cyc - last >= LIMIT) break;
    end
    g = bus.tick_os ? cyc - last : -1;
    last = cyc;
    e = sb.pop_front();
    checks++;
    if (g != e.gap || bus.tick_bit != e.tb || bus.baud_out != e.bo) begin
      errors++;
      $display("FAIL tick %0d: gap %0d bit %0b baud %0b, expected gap %0d bit %0b baud %0b",
               k, g, bus.tick_bit, bus.baud_out, e.gap, e.tb, e.bo);
    end
    k++;
  endtask
  task automatic start(input sel_t s, input bit we, input int d);
    bus.en = 1'b0;
    bus.baud_sel = s;
    bus.div_we = we;
    bus.div_in = d[23:0];
    @(negedge clk);
    bus.div_we = 1'b0;
    @(negedge clk);
    bus.en = 1'b1;
    last = cyc;
    mdl_reset();
  endtask
  initial begin
    int bad;
    tbl = '{
      '{SEL_B1, 1'b0, 325, 133, 18},
      '{SEL_B2, 1'b0, 162, 195, 18},
      '{SEL_B0, 1'b0, 1302, 21, 3},
      '{SEL_CUST, 1'b0, 27, 32, 34},
      '{SEL_CUST, 1'b1, 1, 0, 34},
      '{SEL_CUST, 1'b1, 0, 0, 18},
      '{SEL_CUST, 1'b1, 5, 128, 18},
      '{SEL_CUST, 1'b1, 1, 255, 18},
      '{SEL_CUST, 1'b1, 40, 0, 4}
    };
    rst = 1'b1;
    bus.en = 1'b0;
    bus.baud_sel = SEL_B1;
    bus.div_we = 1'b0;
    bus.div_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_tick_os", bus.tick_os, 0);
    chk("rst_tick_bit", bus.tick_bit, 0);
    chk("rst_baud_out", bus.baud_out, 0);
    chk("rst_sel_pending", bus.sel_pending, 0);
    rst = 1'b0;
    @(negedge clk);
    foreach (tbl[j]) begin
      start(tbl[j].sel, tbl[j].we, tbl[j].i * 256 + tbl[j].f);
      chk("pend_en_low", bus.sel_pending, 0);
      repeat (tbl[j].n) chk_tick(tbl[j].i, tbl[j].f);
    end
    bus.div_we = 1'b1;
    bus.div_in = 24'(30 * 256);
    @(negedge clk);
    bus.div_we = 1'b0;
    while (k < 16) chk_tick(40, 0);
    repeat (16) chk_tick(30, 0);
    chk("pend_custom", bus.sel_pending, 0);
    bus.div_we = 1'b1;
    bus.div_in = 24'(20 * 256);
    @(negedge clk);
    bus.div_we = 1'b0;
    repeat (16) chk_tick(30, 0);
    repeat (4) chk_tick(20, 0);
    start(SEL_B1, 1'b0, 0);
    repeat (3) chk_tick(325, 133);
    bus.baud_sel = SEL_B0;
    @(negedge clk);
    chk("pend_set", bus.sel_pending, 1);
    bus.baud_sel = SEL_B1;
    @(negedge clk);
    chk("pend_toggle_back", bus.sel_pending, 0);
    while (k < 18) chk_tick(325, 133);
    start(SEL_B0, 1'b0, 0);
    repeat (5) chk_tick(1302, 21);
    bus.baud_sel = SEL_B2;
    @(negedge clk);
    chk("pend_mid_bit", bus.sel_pending, 1);
    while (k < 16) chk_tick(1302, 21);
    chk("pend_at_tick_bit", bus.sel_pending, 1);
    while (k < 32) begin
      chk_tick(162, 195);
      if (k == 17) chk("pend_cleared", bus.sel_pending, 0);
    end
    while (k < 42) chk_tick(162, 195);
    repeat (20) @(negedge clk);
    chk("baud_mid_bit", bus.baud_out, 1);
    rst = 1'b1;
    bus.baud_sel = SEL_B1;
    @(negedge clk);
    chk("rst_mid_tick_os", bus.tick_os, 0);
    chk("rst_mid_tick_bit", bus.tick_bit, 0);
    chk("rst_mid_baud_out", bus.baud_out, 0);
    chk("rst_mid_sel_pending", bus.sel_pending, 0);
    rst = 1'b0;
    last = cyc;
    mdl_reset();
    repeat (3) chk_tick(325, 133);
    chk("pend_after_rst", bus.sel_pending, 0);
    while (k < 11) chk_tick(325, 133);
    bus.en = 1'b0;
    bad = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.tick_os || bus.tick_bit || bus.baud_out) bad++;
      if (n == 50) bus.baud_sel = SEL_B2;
    end
    chk("en_low_quiet", bad, 0);
    chk("pend_en_low_apply", bus.sel_pending, 0);
    bus.en = 1'b1;
    last = cyc;
    mdl_reset();
    repeat (17) chk_tick(162, 195);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
